// File: rtl/ctrl_pipeline.sv
// Control-signal half of a 5-stage ARM-style pipeline: carries Decode controls through
// Execute/Memory/Writeback, evaluates condition codes in Execute and owns the NZCV register.
module ctrl_pipeline (
    input  logic       clk,
    input  logic       reset,
    input  logic       PCSrcD,
    input  logic       RegWriteD,
    input  logic       MemtoRegD,
    input  logic       MemWriteD,
    input  logic [2:0] ALUControlD,
    input  logic       BranchD,
    input  logic       ALUSrcD,
    input  logic [1:0] FlagWriteD,
    input  logic       NoWriteD,
    input  logic [3:0] CondD,
    input  logic       FlushE,
    input  logic [3:0] ALUFlags,
    output logic [2:0] ALUControlE,
    output logic       ALUSrcE,
    output logic       MemtoRegE,
    output logic       RegWriteE,
    output logic       BranchTakenE,
    output logic       PCSrcM,
    output logic       RegWriteM,
    output logic       MemtoRegM,
    output logic       MemWriteM,
    output logic       PCSrcW,
    output logic       RegWriteW,
    output logic       MemtoRegW,
    output logic [3:0] Flags
);

    typedef struct packed {
        logic       pcsrc;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic [2:0] alu_control;
        logic       branch;
        logic       alu_src;
        logic [1:0] flag_write;
        logic       no_write;
        logic [3:0] cond;
    } ex_ctrl_t;

    // A bubble is an "always" instruction that does nothing.
    localparam ex_ctrl_t BUBBLE = '{
        pcsrc: 1'b0, reg_write: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0,
        alu_control: 3'b000, branch: 1'b0, alu_src: 1'b0, flag_write: 2'b00,
        no_write: 1'b0, cond: 4'b1110
    };

    ex_ctrl_t ex;
    logic     cond_ex;
    logic     n, z, c, v;

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            ex <= BUBBLE;
        end else begin
            ex <= '{
                pcsrc: PCSrcD, reg_write: RegWriteD, mem_to_reg: MemtoRegD,
                mem_write: MemWriteD, alu_control: ALUControlD, branch: BranchD,
                alu_src: ALUSrcD, flag_write: FlagWriteD, no_write: NoWriteD,
                cond: CondD
            };
        end
    end

    // Conditions use the architectural flags only; a flag-setting instruction
    // influences its successor because the register updates on the same edge.
    assign {n, z, c, v} = Flags;

    always_comb begin
        cond_ex = 1'b0;
        case (ex.cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            default: cond_ex = 1'b1;
        endcase
    end

    assign ALUControlE  = ex.alu_control;
    assign ALUSrcE      = ex.alu_src;
    assign MemtoRegE    = ex.mem_to_reg;
    assign RegWriteE    = ex.reg_write;
    assign BranchTakenE = ex.branch & cond_ex;

    always_ff @(posedge clk) begin
        if (reset) begin
            PCSrcM    <= 1'b0;
            RegWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
            MemWriteM <= 1'b0;
        end else begin
            PCSrcM    <= ex.pcsrc & cond_ex;
            RegWriteM <= ex.reg_write & cond_ex & ~ex.no_write;
            MemtoRegM <= ex.mem_to_reg;
            MemWriteM <= ex.mem_write & cond_ex;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            PCSrcW    <= 1'b0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
        end else begin
            PCSrcW    <= PCSrcM;
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
        end
    end

    // NZ and CV are written independently so compares and logical ops can
    // leave the carry/overflow pair untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            Flags <= 4'b0000;
        end else begin
            if (ex.flag_write[1] & cond_ex) Flags[3:2] <= ALUFlags[3:2];
            if (ex.flag_write[0] & cond_ex) Flags[1:0] <= ALUFlags[1:0];
        end
    end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: each step queues the outputs it should cause
// at a given future cycle, and the queue is drained as those cycles arrive.
module tb_ctrl_pipeline;

    logic       clk = 1'b0;
    logic       reset;
    logic       PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, NoWriteD;
    logic [2:0] ALUControlD;
    logic [1:0] FlagWriteD;
    logic [3:0] CondD;
    logic       FlushE;
    logic [3:0] ALUFlags;
    logic [2:0] ALUControlE;
    logic       ALUSrcE, MemtoRegE, RegWriteE, BranchTakenE;
    logic       PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
    logic       PCSrcW, RegWriteW, MemtoRegW;
    logic [3:0] Flags;

    ctrl_pipeline dut (
        .clk(clk), .reset(reset),
        .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .MemWriteD(MemWriteD), .ALUControlD(ALUControlD), .BranchD(BranchD),
        .ALUSrcD(ALUSrcD), .FlagWriteD(FlagWriteD), .NoWriteD(NoWriteD),
        .CondD(CondD), .FlushE(FlushE), .ALUFlags(ALUFlags),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .MemtoRegE(MemtoRegE),
        .RegWriteE(RegWriteE), .BranchTakenE(BranchTakenE),
        .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .MemWriteM(MemWriteM), .PCSrcW(PCSrcW), .RegWriteW(RegWriteW),
        .MemtoRegW(MemtoRegW), .Flags(Flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcsrc;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic [2:0] alu_control;
        logic       branch;
        logic       alu_src;
        logic [1:0] flag_write;
        logic       no_write;
        logic [3:0] cond;
    } dec_t;

    typedef enum int {
        S_REGE, S_ALUCE, S_ALUSRCE, S_MEMTOREGE, S_BRT,
        S_REGM, S_MEMTOREGM, S_MEMWM, S_PCSRCM,
        S_REGW, S_MEMTOREGW, S_PCSRCW, S_FLAGS
    } sel_e;

    typedef struct {
        int         due;
        sel_e       sel;
        logic [3:0] value;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   check_count = 0;
    int   pass_count = 0;
    int   fail_count = 0;

    function automatic dec_t idle();
        dec_t d;
        d = '0;
        d.cond = 4'b1110;
        return d;
    endfunction

    function automatic logic [3:0] sample(input sel_e s);
        logic [3:0] r;
        r = 4'h0;
        case (s)
            S_REGE:      r = {3'b0, RegWriteE};
            S_ALUCE:     r = {1'b0, ALUControlE};
            S_ALUSRCE:   r = {3'b0, ALUSrcE};
            S_MEMTOREGE: r = {3'b0, MemtoRegE};
            S_BRT:       r = {3'b0, BranchTakenE};
            S_REGM:      r = {3'b0, RegWriteM};
            S_MEMTOREGM: r = {3'b0, MemtoRegM};
            S_MEMWM:     r = {3'b0, MemWriteM};
            S_PCSRCM:    r = {3'b0, PCSrcM};
            S_REGW:      r = {3'b0, RegWriteW};
            S_MEMTOREGW: r = {3'b0, MemtoRegW};
            S_PCSRCW:    r = {3'b0, PCSrcW};
            S_FLAGS:     r = Flags;
            default:     r = 4'hx;
        endcase
        return r;
    endfunction

    task automatic push_exp(input int offset, input sel_e sel, input logic [3:0] value);
        exp_t e;
        e.due   = cyc + offset;
        e.sel   = sel;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        logic [3:0] observed;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                observed = sample(sb[i].sel);
                check_count++;
                assert (observed === sb[i].value) pass_count++;
                else begin
                    fail_count++;
                    $error("[TB] FAIL %s cycle=%0d observed=%b expected=%b",
                           sb[i].sel.name(), cyc, observed, sb[i].value);
                end
                sb.delete(i);
            end
        end
    endtask

    task automatic applyStimulus(input dec_t d, input logic flush,
                                 input logic [3:0] alu, input logic rst);
        {PCSrcD, RegWriteD, MemtoRegD, MemWriteD, ALUControlD, BranchD,
         ALUSrcD, FlagWriteD, NoWriteD, CondD} = d;
        FlushE   = flush;
        ALUFlags = alu;
        reset    = rst;
        @(posedge clk);
        #1;
        cyc++;
        checkOutput();
    endtask

    // One branch per condition code; mask bit i is the expected BranchTakenE for cond i.
    task automatic condSweep(input logic [15:0] mask);
        dec_t d;
        for (int i = 0; i < 16; i++) begin
            d = idle();
            d.branch = 1'b1;
            d.cond = 4'(i);
            push_exp(1, S_BRT, {3'b0, mask[i]});
            applyStimulus(d, 1'b0, 4'h0, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        dec_t d;

        // Reset held two cycles while Decode presents a writing, flag-setting instruction
        d = idle(); d.reg_write = 1'b1; d.flag_write = 2'b11;
        push_exp(1, S_REGE, 0); push_exp(1, S_REGM, 0); push_exp(1, S_REGW, 0);
        push_exp(1, S_FLAGS, 4'b0000); push_exp(1, S_PCSRCM, 0);
        push_exp(1, S_MEMWM, 0); push_exp(1, S_BRT, 0);
        applyStimulus(d, 1'b1, 4'b1111, 1'b1);
        push_exp(1, S_REGE, 0); push_exp(1, S_REGM, 0); push_exp(1, S_REGW, 0);
        push_exp(1, S_FLAGS, 4'b0000);
        applyStimulus(d, 1'b0, 4'b1111, 1'b1);
        d = idle();
        push_exp(1, S_REGE, 0); push_exp(1, S_REGM, 0); push_exp(1, S_REGW, 0);
        push_exp(1, S_FLAGS, 4'b0000); push_exp(1, S_ALUCE, 0);
        applyStimulus(d, 1'b0, 4'h0, 1'b0);

        // Single-instruction latency through E, M, W
        d = idle(); d.reg_write = 1'b1; d.mem_to_reg = 1'b1;
        d.alu_control = 3'b101; d.alu_src = 1'b1;
        push_exp(1, S_REGE, 1); push_exp(1, S_ALUCE, 4'd5);
        push_exp(1, S_ALUSRCE, 1); push_exp(1, S_MEMTOREGE, 1);
        push_exp(2, S_REGM, 1); push_exp(2, S_MEMTOREGM, 1);
        push_exp(3, S_REGW, 1); push_exp(3, S_MEMTOREGW, 1);
        push_exp(2, S_REGE, 0); push_exp(3, S_REGM, 0); push_exp(4, S_REGW, 0);
        applyStimulus(d, 1'b0, 4'h0, 1'b0);
        repeat (3) applyStimulus(idle(), 1'b0, 4'h0, 1'b0);

        // CMP sets Z, following ADDEQ must execute
        d = idle(); d.flag_write = 2'b11; d.no_write = 1'b1; d.reg_write = 1'b1;
        push_exp(1, S_FLAGS, 4'b0000); push_exp(1, S_REGE, 1);
        push_exp(2, S_REGM, 0); push_exp(2, S_FLAGS, 4'b0100); push_exp(3, S_REGW, 0);
        applyStimulus(d, 1'b0, 4'h0, 1'b0);
        d = idle(); d.reg_write = 1'b1; d.cond = 4'b0000;
        push_exp(1, S_REGE, 1); push_exp(2, S_REGM, 1); push_exp(3, S_REGW, 1);
        applyStimulus(d, 1'b0, 4'b0100, 1'b0);

        // Flag write under a failing condition (NE with Z=1) must not land
        d = idle(); d.flag_write = 2'b11; d.cond = 4'b0001;
        push_exp(2, S_FLAGS, 4'b0100);
        applyStimulus(d, 1'b0, 4'h0, 1'b0);
        applyStimulus(idle(), 1'b0, 4'b1111, 1'b0);

        // Clear flags back to 0000
        d = idle(); d.flag_write = 2'b11;
        push_exp(1, S_FLAGS, 4'b0100); push_exp(2, S_FLAGS, 4'b0000);
        applyStimulus(d, 1'b0, 4'b1111, 1'b0);
        applyStimulus(idle(), 1'b0, 4'b0000, 1'b0);

        // Suppressed branch/store (EQ, Z=0), then the same under NE
        d = idle(); d.mem_write = 1'b1; d.branch = 1'b1; d.pcsrc = 1'b1;
        d.reg_write = 1'b1; d.cond = 4'b0000;
        push_exp(1, S_BRT, 0); push_exp(2, S_MEMWM, 0); push_exp(2, S_PCSRCM, 0);
        push_exp(2, S_REGM, 0); push_exp(2, S_FLAGS, 4'b0000); push_exp(3, S_PCSRCW, 0);
        applyStimulus(d, 1'b0, 4'h0, 1'b0);
        d.cond = 4'b0001;
        push_exp(1, S_BRT, 1); push_exp(2, S_MEMWM, 1); push_exp(2, S_PCSRCM, 1);
        push_exp(2, S_REGM, 1); push_exp(3, S_PCSRCW, 1); push_exp(3, S_REGW, 1);
        applyStimulus(d, 1'b0, 4'h0, 1'b0);
        push_exp(2, S_MEMWM, 0);
        repeat (3) applyStimulus(idle(), 1'b0, 4'h0, 1'b0);

        // Flush: E becomes a bubble, the instruction leaving E still completes
        d = idle(); d.reg_write = 1'b1; d.mem_write = 1'b1; d.flag_write = 2'b11;
        push_exp(2, S_REGM, 1); push_exp(2, S_MEMWM, 1); push_exp(3, S_REGW, 1);
        applyStimulus(d, 1'b0, 4'h0, 1'b0);
        d = idle(); d.reg_write = 1'b1; d.mem_write = 1'b1;
        push_exp(1, S_REGE, 0); push_exp(1, S_FLAGS, 4'b1010);
        push_exp(2, S_REGM, 0); push_exp(2, S_MEMWM, 0); push_exp(3, S_REGW, 0);
        applyStimulus(d, 1'b1, 4'b1010, 1'b0);
        repeat (2) applyStimulus(idle(), 1'b0, 4'h0, 1'b0);

        // All condition codes with NZCV=1010
        condSweep(16'hE996);

        // Partial flag writes: 1111 -> (NZ only) 0011 -> (CV only) 0010
        d = idle(); d.flag_write = 2'b11;
        applyStimulus(d, 1'b0, 4'h0, 1'b0);
        d = idle(); d.flag_write = 2'b10;
        push_exp(1, S_FLAGS, 4'b1111);
        applyStimulus(d, 1'b0, 4'b1111, 1'b0);
        d = idle(); d.flag_write = 2'b01;
        push_exp(1, S_FLAGS, 4'b0011);
        applyStimulus(d, 1'b0, 4'b0000, 1'b0);
        push_exp(1, S_FLAGS, 4'b0010);
        applyStimulus(idle(), 1'b0, 4'b1110, 1'b0);

        // All condition codes with NZCV=0010
        condSweep(16'hD5A6);

        // Reset with instructions in flight discards them
        d = idle(); d.reg_write = 1'b1; d.mem_write = 1'b1; d.pcsrc = 1'b1;
        d.flag_write = 2'b11;
        push_exp(2, S_REGM, 1); push_exp(2, S_PCSRCM, 1);
        applyStimulus(d, 1'b0, 4'h0, 1'b0);
        push_exp(1, S_FLAGS, 4'b1111);
        applyStimulus(d, 1'b0, 4'b1111, 1'b0);
        push_exp(1, S_REGE, 0); push_exp(1, S_REGM, 0); push_exp(1, S_REGW, 0);
        push_exp(1, S_MEMWM, 0); push_exp(1, S_PCSRCM, 0); push_exp(1, S_PCSRCW, 0);
        push_exp(1, S_FLAGS, 4'b0000);
        applyStimulus(d, 1'b1, 4'b1111, 1'b1);
        push_exp(1, S_REGM, 0); push_exp(1, S_REGW, 0); push_exp(1, S_PCSRCW, 0);
        push_exp(1, S_MEMWM, 0); push_exp(1, S_FLAGS, 4'b0000);
        applyStimulus(idle(), 1'b0, 4'b1111, 1'b0);
        push_exp(1, S_REGW, 0);
        applyStimulus(idle(), 1'b0, 4'h0, 1'b0);

        foreach (sb[i]) begin
            check_count++;
            fail_count++;
            $error("[TB] FAIL %s due=%0d observed=none expected=%b",
                   sb[i].sel.name(), sb[i].due, sb[i].value);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
